xadc_drp_scanner: RTL
=====================

Name: xadc_drp_scanner

Overview:
- Sits directly upstream of the LED-brightness/PWM logic and owns the XADC Wizard DRP port.
- On each XADC end-of-conversion it issues one DRP read for the next auxiliary channel, round-robin over 4 channels.
- Averages 2^AVG_LOG2 samples per channel and emits one averaged 12-bit result per channel with a one-cycle valid strobe.
- Replaces ad-hoc drdy edge detection with an explicit request/wait handshake that includes a timeout.

Parameters:
- CH0_ADDR, 7'h1E, DRP address of channel 0 (VAUX14)
- CH1_ADDR, 7'h17, DRP address of channel 1 (VAUX7)
- CH2_ADDR, 7'h1F, DRP address of channel 2 (VAUX15)
- CH3_ADDR, 7'h16, DRP address of channel 3 (VAUX6)
- AVG_LOG2, 2, log2 of samples averaged per channel; legal range 0..4
- TIMEOUT, 255, max cycles in WAIT for drdy before abort; legal range 1..255

Ports:
- clk  in  1  system clock; also the XADC dclk
- resetn  in  1  synchronous, active-low reset
- eoc  in  1  XADC eoc_out
- drdy  in  1  XADC drdy_out
- do_in  in  16  XADC do_out
- den  out  1  XADC den_in
- dwe  out  1  XADC dwe_in; constant 0
- daddr  out  7  XADC daddr_in
- avg_data  out  12  averaged sample for avg_ch
- avg_ch  out  2  channel index of avg_data
- avg_valid  out  1  one-cycle strobe; avg_data/avg_ch valid this cycle
- timeout_err  out  1  sticky flag: a DRP read timed out

Behaviour:
- Clocking and reset: single clock domain (clk). Reset is synchronous, active-low (resetn).
- Reset values (resetn low at a clk edge):
  - den=0, dwe=0, daddr=CH0_ADDR
  - avg_data=0, avg_ch=0, avg_valid=0, timeout_err=0
  - state=IDLE, channel index ch=0
  - all accumulators and per-channel counts cleared
- Reset asserted mid-transaction aborts the transaction. Any drdy arriving after reset is ignored (state is IDLE).
- daddr is registered and always reflects ch: 0->CH0_ADDR, 1->CH1_ADDR, 2->CH2_ADDR, 3->CH3_ADDR.
- FSM:
  - IDLE: on eoc=1, go to REQ.
  - REQ: den=1 for exactly this one cycle; go to WAIT; load the timeout counter with 0.
  - WAIT: den=0.
    - If drdy=1: capture do_in[15:4] as the sample, go to ACC.
    - Else if the timeout counter reaches TIMEOUT-1: set timeout_err=1, advance ch (mod 4), discard the transaction, go to IDLE.
    - Else increment the timeout counter.
  - ACC: acc[ch] += sample; cnt[ch] += 1.
    - If the new cnt[ch] equals 2^AVG_LOG2: register avg_data = (acc[ch]+sample) >> AVG_LOG2, avg_ch = ch, avg_valid=1 for one cycle; clear acc[ch] and cnt[ch].
    - Advance ch (mod 4), go to IDLE.
- Latency:
  - den rises 2 cycles after the eoc edge is sampled.
  - avg_valid rises 2 cycles after the completing drdy is sampled.
- Widths:
  - acc[ch] is 12+AVG_LOG2 bits; it cannot overflow because the count is cleared at 2^AVG_LOG2.
  - cnt[ch] is AVG_LOG2+1 bits.
  - Division is a truncating right shift, no rounding.
- AVG_LOG2=0: every sample produces avg_valid; avg_data equals do_in[15:4].
- Boundary conditions:
  - eoc while in REQ/WAIT/ACC: ignored, not queued.
  - drdy while in IDLE or REQ: ignored.
  - eoc and drdy in the same WAIT cycle: drdy is serviced and eoc is dropped.
  - Timeout leaves acc/cnt of the skipped channel unchanged; that channel resumes accumulation on its next turn.
  - timeout_err is cleared only by reset.
  - A drdy coincident with the final timeout cycle is treated as a valid read, i.e. drdy has priority over timeout.
- ch wraps 3->0. Outputs for the 4 channels therefore appear in order 0,1,2,3 when all reads succeed.

Test Plan:
- Reset: hold resetn=0 for 3 cycles while eoc and drdy toggle -> den=0, avg_valid=0, timeout_err=0, daddr=7'h1E throughout.
- Round-robin, AVG_LOG2=0: 4 eoc/drdy transactions returning do_in=16'hFFF0, 16'h8000, 16'h0010, 16'h0000 -> daddr sequence 1E,17,1F,16; avg_data=FFF,800,001,000 with avg_ch=0,1,2,3; den high exactly 1 cycle per eoc.
- Averaging, AVG_LOG2=2: channel 0 returns do_in[15:4]=100,101,102,104 over 4 passes (other channels return 0) -> exactly one avg_valid with avg_ch=0 and avg_data=101 (407>>2, truncated), on the 4th pass only.
- Timeout, TIMEOUT=8: issue eoc, never assert drdy -> timeout_err=1 on the 8th WAIT cycle and ch advances to 1 (daddr=17). A second eoc -> den pulses again and normal operation resumes.
- Collisions: eoc pulses every cycle while drdy returns 5 cycles after den -> only one den per transaction. Also assert drdy in the same cycle the timeout would fire -> sample accepted, timeout_err stays 0.
- Reset mid-WAIT: resetn low for 1 cycle after den, then drdy arrives -> no avg_valid, ch=0, accumulators zero; the next transaction reads channel 0 cleanly.

Source files
------------

// File: rtl/xadc_drp_scanner.sv
`default_nettype none
// ============================================================================
// Module   : xadc_drp_scanner
// Brief    : Round-robin XADC DRP reader with per-channel sample averaging.
// Revision : 1.0 - initial release
// ============================================================================
module xadc_drp_scanner #(
    parameter logic [6:0]  CH0_ADDR = 7'h1E,
    parameter logic [6:0]  CH1_ADDR = 7'h17,
    parameter logic [6:0]  CH2_ADDR = 7'h1F,
    parameter logic [6:0]  CH3_ADDR = 7'h16,
    parameter int unsigned AVG_LOG2 = 2,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        eoc,
    input  logic        drdy,
    input  logic [15:0] do_in,
    output logic        den,
    output logic        dwe,
    output logic [6:0]  daddr,
    output logic [11:0] avg_data,
    output logic [1:0]  avg_ch,
    output logic        avg_valid,
    output logic        timeout_err
);

    localparam int unsigned   AW         = 12 + AVG_LOG2;
    localparam int unsigned   CW         = AVG_LOG2 + 1;
    localparam logic [CW-1:0] c_full     = CW'(1 << AVG_LOG2);
    localparam logic [7:0]    c_tmo_last = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_ACC  = 2'd3
    } state_t;

    state_t        state_q;
    logic [1:0]    ch_q;
    logic [6:0]    daddr_q;
    logic          den_q;
    logic [7:0]    tcnt_q;
    logic [11:0]   sample_q;
    logic [AW-1:0] acc_q [4];
    logic [CW-1:0] cnt_q [4];
    logic [11:0]   avg_data_q;
    logic [1:0]    avg_ch_q;
    logic          avg_valid_q;
    logic          err_q;

    logic [AW-1:0] w_acc_sum;
    logic [CW-1:0] w_cnt_next;
    logic [1:0]    w_ch_next;
    logic          w_unused_lsbs;

    function automatic logic [6:0] addr_of(input logic [1:0] c);
        case (c)
            2'd0:    return CH0_ADDR;
            2'd1:    return CH1_ADDR;
            2'd2:    return CH2_ADDR;
            default: return CH3_ADDR;
        endcase
    endfunction

    assign w_acc_sum     = acc_q[ch_q] + AW'(sample_q);
    assign w_cnt_next    = cnt_q[ch_q] + CW'(1);
    assign w_ch_next     = ch_q + 2'd1;
    assign w_unused_lsbs = ^do_in[3:0];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            ch_q        <= 2'd0;
            daddr_q     <= CH0_ADDR;
            den_q       <= 1'b0;
            tcnt_q      <= 8'd0;
            sample_q    <= 12'd0;
            avg_data_q  <= 12'd0;
            avg_ch_q    <= 2'd0;
            avg_valid_q <= 1'b0;
            err_q       <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                acc_q[i] <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            den_q       <= 1'b0;
            avg_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (eoc) begin
                        state_q <= S_REQ;
                    end
                end
                S_REQ: begin
                    den_q   <= 1'b1;
                    tcnt_q  <= 8'd0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // drdy wins over a timeout that would expire this same cycle
                    if (drdy) begin
                        sample_q <= do_in[15:4];
                        state_q  <= S_ACC;
                    end else if (tcnt_q == c_tmo_last) begin
                        err_q   <= 1'b1;
                        ch_q    <= w_ch_next;
                        daddr_q <= addr_of(w_ch_next);
                        state_q <= S_IDLE;
                    end else begin
                        tcnt_q <= tcnt_q + 8'd1;
                    end
                end
                S_ACC: begin
                    if (w_cnt_next == c_full) begin
                        avg_data_q   <= 12'(w_acc_sum >> AVG_LOG2);
                        avg_ch_q     <= ch_q;
                        avg_valid_q  <= 1'b1;
                        acc_q[ch_q]  <= '0;
                        cnt_q[ch_q]  <= '0;
                    end else begin
                        acc_q[ch_q]  <= w_acc_sum;
                        cnt_q[ch_q]  <= w_cnt_next;
                    end
                    ch_q    <= w_ch_next;
                    daddr_q <= addr_of(w_ch_next);
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign den         = den_q;
    assign dwe         = 1'b0;
    assign daddr       = daddr_q;
    assign avg_data    = avg_data_q;
    assign avg_ch      = avg_ch_q;
    assign avg_valid   = avg_valid_q;
    assign timeout_err = err_q;

endmodule
`default_nettype wire
